// File: rtl/b10_resp_capture_if.sv
// Bundle of the sampled b10 DUT outputs, capture window and FIFO readout port
// for b10_resp_capture.
//   master: bench/driver side (drives cts, ctr, v_out, enable, rd_ready)
//   slave : b10_resp_capture (drives rd_valid, rd_data, signature, overflow,
//           level, busy)
interface b10_resp_capture_if #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned STAMP_W = 16,
   parameter int unsigned VW      = 4
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic                    cts;
   logic                    ctr;
   logic [VW-1:0]           v_out;
   logic                    enable;
   logic                    rd_ready;
   logic                    rd_valid;
   logic [STAMP_W+VW+1:0]   rd_data;
   logic [15:0]             signature;
   logic                    overflow;
   logic [LW-1:0]           level;
   logic                    busy;

   modport master (
      output cts, ctr, v_out, enable, rd_ready,
      input  rd_valid, rd_data, signature, overflow, level, busy
   );

   modport slave (
      input  cts, ctr, v_out, enable, rd_ready,
      output rd_valid, rd_data, signature, overflow, level, busy
   );
endinterface

// File: rtl/b10_resp_capture.sv
// b10_resp_capture: samples {cts, ctr, v_out} every RUN cycle, queues a
// time-stamped entry for every change into a DEPTH-entry FIFO and folds every
// sample into a 16-bit MISR signature.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - b10_resp_capture_if.slave: sampled inputs, enable, readout port
//            (rd_valid/rd_ready/rd_data), signature, overflow, level, busy
// Build option: define B10_RESP_SIG_EN to include the MISR; otherwise the
// signature output is tied to zero.
module b10_resp_capture #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned STAMP_W = 16,
   parameter int unsigned VW      = 4
) (
   input  logic               clock,
   input  logic               reset,
   b10_resp_capture_if.slave  bus
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned LW   = AW + 1;
   localparam int unsigned VECW = VW + 2;
   localparam int unsigned EW   = STAMP_W + VECW;

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e              state_q, state_d;
   logic [VECW-1:0]     vec;
   logic [STAMP_W-1:0]  stamp_q, stamp_d;
   logic [VECW-1:0]     last_q, last_d;
   logic                first_q, first_d;
   logic                ovf_q, ovf_d;
   logic [EW-1:0]       mem_q [DEPTH];
   logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0]       level_q, level_d;
   logic [EW-1:0]       rdata_q, rdata_d;
   logic                start, sample, full, pop, push_req, push;
   logic [EW-1:0]       entry;

   assign vec = {bus.cts, bus.ctr, bus.v_out};

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.enable) state_d = StRun;
         StRun:   if (!bus.enable) state_d = StDrain;
         // Leave once the FIFO is (or becomes at this edge) empty.
         StDrain: if (level_d == '0) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      start  = (state_q == StIdle) && bus.enable;
      sample = (state_q == StRun) && bus.enable;
   end

   // ---------------- capture bookkeeping ----------------
   always_comb begin
      full     = (level_q == LW'(DEPTH));
      pop      = (level_q != '0) && bus.rd_ready;
      push_req = sample && (first_q || (vec != last_q));
      // A full FIFO still accepts a push when the head leaves at the same edge.
      push     = push_req && (!full || pop);
      entry    = {stamp_q, vec};

      stamp_d = stamp_q;
      first_d = first_q;
      last_d  = last_q;
      ovf_d   = ovf_q;
      if (start) begin
         stamp_d = '0;
         first_d = 1'b1;
         ovf_d   = 1'b0;
      end else if (sample) begin
         last_d  = vec;
         first_d = 1'b0;
         if (stamp_q != '1) stamp_d = stamp_q + 1'b1;
         if (push_req && !push) ovf_d = 1'b1;
      end
   end

   // ---------------- FIFO pointers and registered head ----------------
   always_comb begin
      wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
      level_d = level_q + LW'(push) - LW'(pop);
      rdata_d = rdata_q;
      if (level_q == '0) begin
         if (push) rdata_d = entry;
      end else if (pop) begin
         if (level_q == LW'(1)) begin
            // Last entry leaves; the new head is the incoming one, or the
            // output simply holds when the FIFO goes empty.
            if (push) rdata_d = entry;
         end else begin
            rdata_d = mem_q[rptr_d];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stamp_q <= '0;
         last_q  <= '0;
         first_q <= 1'b1;
         ovf_q   <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         rdata_q <= '0;
      end else begin
         stamp_q <= stamp_d;
         last_q  <= last_d;
         first_q <= first_d;
         ovf_q   <= ovf_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage needs no reset: it is only read through valid pointers.
   always_ff @(posedge clock) begin
      if (push) mem_q[wptr_q] <= entry;
   end

   // ---------------- MISR ----------------
`ifdef B10_RESP_SIG_EN
   logic [15:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (start) begin
         sig_d = 16'hFFFF;
      end else if (sample) begin
         sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ 16'(vec);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sig_q <= 16'hFFFF;
      else        sig_q <= sig_d;
   end

   assign bus.signature = sig_q;
`else
   assign bus.signature = 16'h0000;
`endif

   assign bus.rd_valid = (level_q != '0);
   assign bus.rd_data  = rdata_q;
   assign bus.overflow = ovf_q;
   assign bus.level    = level_q;
   assign bus.busy     = (state_q != StIdle);
endmodule

// File: tb/tb_b10_resp_capture.sv
// Self-checking bench for b10_resp_capture: a reference model keeps the
// expected FIFO contents in a queue and the expected MISR/overflow state.
module tb_b10_resp_capture;
   localparam int unsigned DEPTH   = 8;
   localparam int unsigned STAMP_W = 16;
   localparam int unsigned VW      = 4;
   localparam int unsigned EW      = STAMP_W + VW + 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   b10_resp_capture_if #(.DEPTH(DEPTH), .STAMP_W(STAMP_W), .VW(VW)) bus ();

   b10_resp_capture #(.DEPTH(DEPTH), .STAMP_W(STAMP_W), .VW(VW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state: 0 idle, 1 run, 2 drain.
   int            m_state;
   logic [15:0]   m_stamp;
   logic [15:0]   m_sig;
   logic          m_first;
   logic          m_ovf;
   logic [5:0]    m_last;
   logic [EW-1:0] q[$];

   function automatic logic [15:0] exp_sig();
`ifdef B10_RESP_SIG_EN
      return m_sig;
`else
      return 16'h0000;
`endif
   endfunction

   function automatic logic [15:0] exp_reset_sig();
`ifdef B10_RESP_SIG_EN
      return 16'hFFFF;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic m_reset();
      m_state = 0;
      m_stamp = '0;
      m_sig   = 16'hFFFF;
      m_first = 1'b1;
      m_ovf   = 1'b0;
      m_last  = '0;
      q.delete();
   endtask

   task automatic set_vec(input logic [5:0] v);
      {bus.cts, bus.ctr, bus.v_out} = v;
   endtask

   // Advance the model by one edge using the current inputs, then clock the DUT
   // and return 1 time unit after the edge.
   task automatic tick();
      logic [5:0]    vec;
      logic [EW-1:0] entry;
      bit            pop;
      bit            push;
      int            st0;
      vec   = {bus.cts, bus.ctr, bus.v_out};
      pop   = (q.size() != 0) && bus.rd_ready;
      push  = 1'b0;
      st0   = m_state;
      entry = '0;
      case (m_state)
         0: if (bus.enable) begin
            m_state = 1;
            m_stamp = '0;
            m_sig   = 16'hFFFF;
            m_first = 1'b1;
            m_ovf   = 1'b0;
         end
         1: if (!bus.enable) begin
            m_state = 2;
         end else begin
            push    = m_first || (vec != m_last);
            entry   = {m_stamp, vec};
            m_last  = vec;
            m_first = 1'b0;
            m_sig   = {m_sig[14:0], 1'b0} ^ (m_sig[15] ? 16'h1021 : 16'h0000) ^ {10'b0, vec};
            if (m_stamp != 16'hFFFF) m_stamp = m_stamp + 16'd1;
         end
         default: ;
      endcase
      if (pop) void'(q.pop_front());
      if (push) begin
         if (q.size() < DEPTH) q.push_back(entry);
         else m_ovf = 1'b1;
      end
      if (st0 == 2 && q.size() == 0) m_state = 0;
      @(posedge clock);
      #1;
   endtask

   // Pops everything left with rd_ready=1 until busy falls (bounded).
   task automatic drain_all(input string name);
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 40 && bus.busy; i++) begin
         total++;
         if (bus.rd_valid !== (q.size() != 0)) begin
            bad++;
            $display("FAIL %s_drain_valid got=%b want=%b", name, bus.rd_valid, q.size() != 0);
         end
         if (bus.rd_valid && q.size() != 0) begin
            total++;
            if (bus.rd_data !== q[0]) begin
               bad++;
               $display("FAIL %s_drain_data got=%h want=%h", name, bus.rd_data, q[0]);
            end
         end
         tick();
      end
      total++;
      if (bus.busy !== 1'b0 || bus.level !== 4'd0) begin
         bad++;
         $display("FAIL %s_drain_end busy=%b level=%0d want busy=0 level=0", name, bus.busy,
                  bus.level);
      end
      bus.rd_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.enable = 1'b0;
      bus.rd_ready = 1'b0;
      set_vec(6'h00);
      m_reset();
      #12;
      total++;
      if ({bus.rd_valid, bus.overflow, bus.busy, bus.level} !== 7'd0 || bus.rd_data !== '0) begin
         bad++;
         $display("FAIL reset_outputs got valid=%b ovf=%b busy=%b level=%0d data=%h want zeros",
                  bus.rd_valid, bus.overflow, bus.busy, bus.level, bus.rd_data);
      end
      total++;
      if (bus.signature !== exp_reset_sig()) begin
         bad++;
         $display("FAIL reset_sig got=%h want=%h", bus.signature, exp_reset_sig());
      end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_const();
      set_vec(6'h00);
      bus.enable = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) tick();
      total++;
      if (bus.level !== 4'd1 || bus.level !== 4'(q.size())) begin
         bad++;
         $display("FAIL const_level got=%0d want=1", bus.level);
      end
      total++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 22'd0) begin
         bad++;
         $display("FAIL const_entry got valid=%b data=%h want valid=1 data=0", bus.rd_valid,
                  bus.rd_data);
      end
      total++;
      if (bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL const_ovf got=%b want=0", bus.overflow);
      end
      bus.enable = 1'b0;
      tick();
      drain_all("const");
   endtask

   task automatic test_changes();
      logic [EW-1:0] exp_tab [3];
      exp_tab[0] = {16'd0, 6'h00};
      exp_tab[1] = {16'd3, 6'h05};
      exp_tab[2] = {16'd7, 6'h25};
      set_vec(6'h00);
      bus.enable = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) begin
         bus.v_out = (k >= 3) ? 4'h5 : 4'h0;
         bus.cts   = (k >= 7);
         tick();
      end
      total++;
      if (bus.level !== 4'd3) begin
         bad++;
         $display("FAIL changes_level got=%0d want=3", bus.level);
      end
      bus.enable = 1'b0;
      tick();
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_tab[i] || q.size() == 0 ||
             bus.rd_data !== q[0]) begin
            bad++;
            $display("FAIL changes_entry%0d got valid=%b data=%h want data=%h", i, bus.rd_valid,
                     bus.rd_data, exp_tab[i]);
         end
         tick();
      end
      total++;
      if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL changes_end got valid=%b busy=%b want 0 0", bus.rd_valid, bus.busy);
      end
      bus.rd_ready = 1'b0;
      set_vec(6'h00);
   endtask

   task automatic test_overflow();
      bus.rd_ready = 1'b0;
      bus.enable = 1'b1;
      tick();
      for (int k = 0; k < 12; k++) begin
         set_vec(k[0] ? 6'h0A : 6'h15);
         tick();
         if (k >= 7) begin
            total++;
            if (bus.rd_valid !== 1'b1) begin
               bad++;
               $display("FAIL ovf_valid edge%0d got=%b want=1", k, bus.rd_valid);
            end
         end
      end
      total++;
      if (bus.level !== 4'd8 || bus.overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_state got level=%0d ovf=%b want level=8 ovf=1", bus.level,
                  bus.overflow);
      end
      total++;
      if (bus.rd_data !== {16'd0, 6'h15}) begin
         bad++;
         $display("FAIL ovf_head got=%h want=%h", bus.rd_data, {16'd0, 6'h15});
      end
   endtask

   task automatic test_full_pop();
      bus.rd_ready = 1'b1;
      set_vec(6'h15);
      total++;
      if (bus.rd_data !== q[0]) begin
         bad++;
         $display("FAIL fullpop_head got=%h want=%h", bus.rd_data, q[0]);
      end
      tick();
      total++;
      if (bus.level !== 4'd8 || bus.overflow !== 1'b1) begin
         bad++;
         $display("FAIL fullpop_state got level=%0d ovf=%b want level=8 ovf=1", bus.level,
                  bus.overflow);
      end
      total++;
      if (bus.rd_data !== {16'd1, 6'h0A} || bus.rd_data !== q[0]) begin
         bad++;
         $display("FAIL fullpop_newhead got=%h want=%h", bus.rd_data, {16'd1, 6'h0A});
      end
      bus.rd_ready = 1'b0;
      bus.enable = 1'b0;
      tick();
      drain_all("fullpop");
   endtask

   task automatic test_sig();
      set_vec(6'h00);
      bus.enable = 1'b1;
      tick();
      total++;
      if (bus.signature !== exp_reset_sig() || bus.overflow !== 1'b0) begin
         bad++;
         $display("FAIL sig_start got sig=%h ovf=%b want sig=%h ovf=0", bus.signature,
                  bus.overflow, exp_reset_sig());
      end
      tick();
      total++;
`ifdef B10_RESP_SIG_EN
      if (bus.signature !== 16'hEFDF) begin
         bad++;
         $display("FAIL sig_first got=%h want=efdf", bus.signature);
      end
`else
      if (bus.signature !== 16'h0000) begin
         bad++;
         $display("FAIL sig_first got=%h want=0000", bus.signature);
      end
`endif
      for (int k = 0; k < 8; k++) begin
         set_vec(6'($urandom_range(0, 63)));
         tick();
         total++;
         if (bus.signature !== exp_sig()) begin
            bad++;
            $display("FAIL sig_step%0d got=%h want=%h", k, bus.signature, exp_sig());
         end
      end
      bus.enable = 1'b0;
      tick();
      total++;
      if (bus.signature !== exp_sig()) begin
         bad++;
         $display("FAIL sig_frozen got=%h want=%h", bus.signature, exp_sig());
      end
      drain_all("sig");
   endtask

   task automatic test_drain_busy();
      bus.rd_ready = 1'b0;
      set_vec(6'h00);
      bus.enable = 1'b1;
      tick();
      for (int k = 1; k <= 3; k++) begin
         set_vec(6'(k));
         tick();
      end
      bus.enable = 1'b0;
      tick();
      total++;
      if (bus.busy !== 1'b1 || bus.level !== 4'd3) begin
         bad++;
         $display("FAIL drain_enter got busy=%b level=%0d want busy=1 level=3", bus.busy,
                  bus.level);
      end
      bus.enable = 1'b1;  // must be ignored while draining
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bus.rd_data !== q[0]) begin
            bad++;
            $display("FAIL drain_pop%0d got=%h want=%h", i, bus.rd_data, q[0]);
         end
         tick();
         total++;
         if (bus.busy !== (i < 2)) begin
            bad++;
            $display("FAIL drain_busy%0d got=%b want=%b", i, bus.busy, i < 2);
         end
      end
      bus.enable = 1'b0;
      bus.rd_ready = 1'b0;
      total++;
      if (bus.level !== 4'd0 || bus.rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL drain_empty got level=%0d valid=%b want 0 0", bus.level, bus.rd_valid);
      end
      tick();
   endtask

   task automatic test_async_reset();
      set_vec(6'h00);
      bus.enable = 1'b1;
      tick();
      set_vec(6'h01);
      tick();
      set_vec(6'h02);
      tick();
      #3;
      reset = 1'b0;
      #1;
      total++;
      if ({bus.rd_valid, bus.overflow, bus.busy, bus.level} !== 7'd0 || bus.rd_data !== '0) begin
         bad++;
         $display("FAIL areset_outputs got valid=%b ovf=%b busy=%b level=%0d data=%h want zeros",
                  bus.rd_valid, bus.overflow, bus.busy, bus.level, bus.rd_data);
      end
      total++;
      if (bus.signature !== exp_reset_sig()) begin
         bad++;
         $display("FAIL areset_sig got=%h want=%h", bus.signature, exp_reset_sig());
      end
      m_reset();
      bus.enable = 1'b0;
      #2;
      reset = 1'b1;
      tick();
      total++;
      if (bus.busy !== 1'b0 || bus.level !== 4'd0) begin
         bad++;
         $display("FAIL areset_after got busy=%b level=%0d want 0 0", bus.busy, bus.level);
      end
   endtask

   initial begin
      test_reset();
      test_const();
      test_changes();
      test_overflow();
      test_full_pop();
      test_sig();
      test_drain_busy();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
